// File: rtl/sm_mem_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The slave view belongs to the arbiter. The master view drives the requests and the memory read data.
interface sm_mem_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sm_mem_arbiter.sv
// Two-port arbiter for a single-port synchronous memory.
// The current owner keeps the bus for up to BURST_MAX grants while the other port waits.
module sm_mem_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    sm_mem_if.slave  bus
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rv0_q, rv0_d;
    logic       rv1_q, rv1_d;
    logic       pick1;
    logic       gnt0, gnt1;

    always_comb begin
        pick1   = 1'b0;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            bus.m0_req & bus.m1_req:  pick1 = (cnt_q < BMAX) ? owner_q : ~owner_q;
            bus.m1_req & ~bus.m0_req: pick1 = 1'b1;
            default:                  pick1 = 1'b0;
        endcase
        // Grants are gated by reset so nothing reaches memory while rst_n is low
        gnt0 = rst_n & bus.m0_req & ~pick1;
        gnt1 = rst_n & bus.m1_req & pick1;
        if (gnt0 | gnt1) begin
            if (pick1 != owner_q) begin
                owner_d = pick1;
                cnt_d   = 4'd1;
            end else if (cnt_q < BMAX) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        rv0_d = gnt0 & ~bus.m0_we;
        rv1_d = gnt1 & ~bus.m1_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rv0_q;
    assign bus.m1_rvalid = rv1_q;
    assign bus.m0_rdata  = bus.mem_rdata;
    assign bus.m1_rdata  = bus.mem_rdata;
    assign bus.mem_addr  = gnt1 ? bus.m1_addr : bus.m0_addr;
    assign bus.mem_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_we    = gnt1 ? bus.m1_we : (gnt0 & bus.m0_we);

endmodule

// File: doc/sm_mem_arbiter.md
SM_MEM_ARBITER -- requirements
Module: sm_mem_arbiter

Interface
REQ-001 Parameter: BURST_MAX, 4, maximum consecutive grants to the current owner while the other port is waiting; legal range 1..15.
REQ-002 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 Port: m0_req  in  1  port 0 (instruction fetch) access request; held with its address and data until m0_gnt.
REQ-005 Port: m0_addr  in  32  port 0 word address.
REQ-006 Port: m0_we  in  1  port 0 write enable (0 = read).
REQ-007 Port: m0_wdata  in  32  port 0 write data.
REQ-008 Port: m0_gnt  out  1  port 0 request accepted this cycle (combinational).
REQ-009 Port: m0_rvalid  out  1  port 0 read data valid this cycle.
REQ-010 Port: m0_rdata  out  32  port 0 read data.
REQ-011 Port: m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same directions and widths as port 0; port 1 is the data/loader port.
REQ-012 Port: mem_addr  out  32  shared single-port memory address.
REQ-013 Port: mem_we  out  1  memory write strobe.
REQ-014 Port: mem_wdata  out  32  memory write data.
REQ-015 Port: mem_rdata  in  32  memory read data; synchronous, valid one cycle after the address.

Function
REQ-016 At most one request SHALL be granted per cycle; gnt SHALL be asserted only when the same port's req is high.
REQ-017 State: owner (1 bit, last granted port) and cnt (4 bits, consecutive grants to owner).
REQ-018 Only one req high: that port SHALL be granted, regardless of owner and cnt.
REQ-019 Both req high: owner SHALL be granted if cnt < BURST_MAX, otherwise the other port SHALL be granted.
REQ-020 On a grant to port p: p != owner -> owner <= p, cnt <= 1; p == owner -> cnt <= cnt+1, saturating at BURST_MAX.
REQ-021 No req in a cycle: owner and cnt SHALL hold; no memory access SHALL occur.
REQ-022 In a grant cycle, mem_addr/mem_wdata SHALL equal the granted port's addr/wdata and mem_we SHALL equal its we; with no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold the port-0 values.
REQ-023 A granted read SHALL produce exactly one rvalid pulse on the granted port in the next cycle, with rdata = mem_rdata; the other port's rvalid SHALL stay 0.
REQ-024 A granted write SHALL produce no rvalid.
REQ-025 m0_rdata and m1_rdata SHALL both be driven from mem_rdata; values are defined only while the respective rvalid is high.
REQ-026 Back-to-back grants SHALL be supported: a new grant in the cycle a previous read's rvalid is high SHALL not corrupt or delay that rvalid.
REQ-027 A request deasserted before gnt SHALL be dropped without side effects; a write is committed only in its gnt cycle.

Reset
REQ-028 While rst_n is low: owner=0, cnt=0, m0_rvalid=0, m1_rvalid=0, mem_we=0, m0_gnt=0, m1_gnt=0.
REQ-029 Reset asserted in the cycle after a granted read SHALL suppress that read's rvalid; no rvalid SHALL appear after reset release for accesses issued before reset.
REQ-030 The first cycle after reset release with both req high SHALL grant port 0.

Verification
REQ-031 Single read: m1_req=1, m1_addr=0x10, m1_we=0 -> m1_gnt=1 same cycle, mem_addr=0x10; next cycle m1_rvalid=1, m1_rdata=mem[0x10], m0_rvalid=0.
REQ-032 Fairness, BURST_MAX=4, both ports requesting continuously from reset -> grant sequence 0,0,0,0,1,1,1,1,0, exactly one gnt per cycle.
REQ-033 Write: m0_req=1, m0_we=1, m0_addr=0x3, m0_wdata=0xDEADBEEF -> mem_we=1 for one cycle with those values, no m0_rvalid; a following m1 read of 0x3 returns 0xDEADBEEF.
REQ-034 Solo port: only m1_req high for 10 cycles with owner=0, cnt=4 -> m1_gnt every cycle, cnt saturates at 4, owner=1; then both high -> port 0 granted.
REQ-035 Reset mid-operation: m0 read granted, rst_n low next cycle -> m0_rvalid stays 0, owner=0, cnt=0; normal grants resume after release.
REQ-036 BURST_MAX=1, both requesting -> strict alternation 0,1,0,1 with matching single-cycle rvalid pulses.
